// File: rtl/sub_pkg.sv
// Shared types and defaults for the chunked sequential subtractor.
// Holds the FSM state enum, default geometry and counter width helper.
package sub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;
  localparam int NCHUNK_DEF = WIDTH_DEF / CHUNK_DEF;

  // A one-chunk build still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(NCHUNK_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow-in and borrow-out.
// One instance is shared across all chunks of an operation.
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] res;

  // Widen by one bit so the top bit becomes the borrow.
  always_comb begin
    res = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
    diff = res[CHUNK-1:0];
    bout = res[CHUNK];
  end

endmodule

// File: rtl/seq_subtractor_16.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle.
// Optional ovf output enabled by defining SUB_SIGNED_OVERFLOW_EN.
module seq_subtractor_16
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_t state;
  state_t state_nxt;

  logic load;
  logic step;
  logic last;
  logic ack;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] d_c;
  logic             bo_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready = 1'b0;
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    ack = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          ack = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the current chunk of the captured operands.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  sub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_c),
    .b   (b_c),
    .bin (borrow),
    .diff(d_c),
    .bout(bo_c)
  );

  // Operand capture, chunk stepping and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      borrow <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        a_q <= a;
        b_q <= b;
        borrow <= bin;
        cnt <= '0;
      end
      if (step) begin
        borrow <= bo_c;
        cnt <= last ? '0 : cnt + CW'(1);
        for (int i = 0; i < NCHUNK; i++) begin
          if (cnt == CW'(i)) begin
            diff[i*CHUNK +: CHUNK] <= d_c;
          end
        end
        if (last) begin
          bout <= bo_c;
          out_valid <= 1'b1;
        end
      end
      if (ack) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SUB_SIGNED_OVERFLOW_EN
  // Signed overflow: operand signs differ and result sign flips from a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (step && last) begin
      ovf <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
             (d_c[CHUNK-1] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_seq_subtractor_16.sv
// Directed bench for seq_subtractor_16 with hand-computed results.
// Checks latency, backpressure, input ignore during CALC and reset abort.
module tb_seq_subtractor_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB_SIGNED_OVERFLOW_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_subtractor_16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SUB_SIGNED_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tbin, input logic [15:0] ed,
                        input logic eb, input logic eo,
                        input bit noisy, input int hold);
    int lat;
    @(negedge clk);
    a = ta;
    b = tb_;
    bin = tbin;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (!noisy) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_calc", 32'(in_ready), 32'd0);
      if (noisy) begin
        a = a ^ 16'hA5C3;
        b = b + 16'h1357;
        bin = ~bin;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'd4);
    chk("diff", 32'(diff), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
`ifdef SUB_SIGNED_OVERFLOW_EN
    chk("ovf", 32'(ovf), 32'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold", {13'd0, out_valid, in_ready, bout, diff},
          {13'd0, 1'b1, 1'b0, eb, ed});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ack_state", {30'd0, out_valid, in_ready}, 32'b01);
    chk("diff_kept", 32'(diff), 32'(ed));
  endtask

  initial begin
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vals", {13'd0, out_valid, in_ready, bout, diff},
        {13'd0, 1'b0, 1'b1, 1'b0, 16'h0000});
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, out_valid, in_ready}, 32'b01);

    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h00FF, 16'h0100, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 6);
    run_op(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1, 0);

    @(negedge clk);
    a = 16'h1234;
    b = 16'h4321;
    bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_vals", {13'd0, out_valid, in_ready, bout, diff},
        {13'd0, 1'b0, 1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", {30'd0, out_valid, in_ready}, 32'b01);
    end

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
